// File: rtl/ahb_timer_pkg.sv
// Shared definitions for the AHB-Lite down-counting timer: register offsets,
// CTRL/STATUS bit positions and the address-phase qualifier.
package ahb_timer_pkg;

    typedef enum logic [1:0] {
        REG_LOAD   = 2'd0,
        REG_VALUE  = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int AHB_DATA_WIDTH    = 32;
    localparam int ADDR_REG_LSB      = 2;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_IE_BIT       = 1;
    localparam int CTRL_ONESHOT_BIT  = 2;
    localparam int CTRL_PRESCALE_LSB = 8;

    localparam int STATUS_FLAG_BIT   = 0;

    // A transfer is accepted only for NONSEQ/SEQ while the bus is ready.
    function automatic logic ahb_xfer_valid(
        input logic hsel,
        input logic hready,
        input logic htrans_active
    );
        return hsel & hready & htrans_active;
    endfunction

endpackage

// File: rtl/ahb_timer_prescaler.sv
// Prescale counter: counts HCLK cycles while enabled and emits a one-cycle
// tick when the count reaches the divisor, then restarts from zero.
module timer_prescaler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] divisor,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // A clear (LOAD write) takes precedence and suppresses the tick.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == divisor) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_timer.sv
// AHB-Lite zero-wait-state timer slave: reloadable down counter with
// prescaler, one-shot mode and a sticky expiry flag driving timer_IRQ.
module ahb_timer
    import ahb_timer_pkg::*;
#(
    parameter int TIMER_WIDTH    = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        timer_IRQ
);

    // Captured address phase
    reg_sel_e addr_q, addr_d;
    logic     write_q, write_d;
    logic     valid_q, valid_d;

    // Timer registers
    logic [TIMER_WIDTH-1:0]    load_q, load_d;
    logic [TIMER_WIDTH-1:0]    value_q, value_d;
    logic                      en_q, en_d;
    logic                      ie_q, ie_d;
    logic                      oneshot_q, oneshot_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      flag_q, flag_d;

    logic wr_en;
    logic load_wr;
    logic ctrl_wr;
    logic status_wr;
    logic tick;
    logic expire;

    // Only HADDR[3:2] and HTRANS[1] matter; every access is a full word.
    logic unused_inputs;
    assign unused_inputs = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE};

    assign HREADYOUT = 1'b1;

    always_comb begin
        valid_d = ahb_xfer_valid(HSEL, HREADY, HTRANS[1]);
        addr_d  = addr_q;
        write_d = write_q;
        if (valid_d) begin
            addr_d  = reg_sel_e'(HADDR[ADDR_REG_LSB +: 2]);
            write_d = HWRITE;
        end
    end

    assign wr_en     = valid_q & write_q;
    assign load_wr   = wr_en & (addr_q == REG_LOAD);
    assign ctrl_wr   = wr_en & (addr_q == REG_CTRL);
    assign status_wr = wr_en & (addr_q == REG_STATUS);

    timer_prescaler #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .enable  (en_q),
        .clear   (load_wr),
        .divisor (prescale_q),
        .tick    (tick)
    );

    // The prescaler already masks its tick during a LOAD write.
    assign expire = tick & (value_q == '0);

    always_comb begin
        load_d     = load_q;
        value_d    = value_q;
        en_d       = en_q;
        ie_d       = ie_q;
        oneshot_d  = oneshot_q;
        prescale_d = prescale_q;
        flag_d     = flag_q;

        if (load_wr) begin
            load_d  = HWDATA[TIMER_WIDTH-1:0];
            value_d = HWDATA[TIMER_WIDTH-1:0];
        end else if (tick) begin
            if (value_q != '0) begin
                value_d = value_q - TIMER_WIDTH'(1);
            end else if (!oneshot_q) begin
                value_d = load_q;
            end
        end

        if (expire && oneshot_q) begin
            en_d = 1'b0;
        end

        // A bus write to CTRL overrides the one-shot auto-disable.
        if (ctrl_wr) begin
            en_d       = HWDATA[CTRL_EN_BIT];
            ie_d       = HWDATA[CTRL_IE_BIT];
            oneshot_d  = HWDATA[CTRL_ONESHOT_BIT];
            prescale_d = HWDATA[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
        end

        if (status_wr && HWDATA[STATUS_FLAG_BIT]) begin
            flag_d = 1'b0;
        end
        if (expire) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_q     <= REG_LOAD;
            write_q    <= 1'b0;
            valid_q    <= 1'b0;
            load_q     <= '0;
            value_q    <= '0;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            oneshot_q  <= 1'b0;
            prescale_q <= '0;
            flag_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            write_q    <= write_d;
            valid_q    <= valid_d;
            load_q     <= load_d;
            value_q    <= value_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            oneshot_q  <= oneshot_d;
            prescale_q <= prescale_d;
            flag_q     <= flag_d;
        end
    end

    always_comb begin
        HRDATA = '0;
        case (addr_q)
            REG_LOAD:   HRDATA[TIMER_WIDTH-1:0] = load_q;
            REG_VALUE:  HRDATA[TIMER_WIDTH-1:0] = value_q;
            REG_CTRL: begin
                HRDATA[CTRL_EN_BIT]                          = en_q;
                HRDATA[CTRL_IE_BIT]                          = ie_q;
                HRDATA[CTRL_ONESHOT_BIT]                     = oneshot_q;
                HRDATA[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH]  = prescale_q;
            end
            REG_STATUS: HRDATA[STATUS_FLAG_BIT] = flag_q;
            default:    HRDATA = '0;
        endcase
    end

    assign timer_IRQ = flag_q & ie_q;

endmodule

// File: tb/tb_ahb_timer.sv
// Directed bench for ahb_timer with a cycle-level reference model of the
// timer rules compared against the bus outputs every cycle.
module tb_ahb_timer;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        timer_IRQ;

    int checks = 0;
    int errors = 0;

    ahb_timer dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .timer_IRQ (timer_IRQ)
    );

    initial begin
        HCLK = 1'b0;
        forever #10 HCLK = ~HCLK;
    end

    // Reference model state
    bit          model_live = 1'b0;
    logic [31:0] m_load, m_value;
    bit          m_en, m_ie, m_os, m_flag;
    bit [7:0]    m_psc, m_pcnt;
    bit          m_valid, m_write;
    bit [1:0]    m_addr;

    function automatic logic [31:0] m_rdata();
        case (m_addr)
            2'd0:    return m_load;
            2'd1:    return m_value;
            2'd2:    return {16'h0, m_psc, 5'h0, m_os, m_ie, m_en};
            default: return {31'h0, m_flag};
        endcase
    endfunction

    task automatic model_step();
        bit          wr;
        bit          tick;
        bit          set_flag;
        logic [31:0] wd;
        if (!HRESETn) begin
            m_load = '0; m_value = '0; m_en = 0; m_ie = 0; m_os = 0;
            m_flag = 0; m_psc = '0; m_pcnt = '0;
            m_valid = 0; m_write = 0; m_addr = '0;
            model_live = 1'b1;
            return;
        end
        wd       = HWDATA;
        wr       = m_valid && m_write;
        set_flag = 0;
        if (wr && m_addr == 2'd0) begin
            m_load  = wd;
            m_value = wd;
            m_pcnt  = '0;
        end else if (m_en) begin
            tick   = (m_pcnt == m_psc);
            m_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
            if (tick) begin
                if (m_value > 0) begin
                    m_value = m_value - 1;
                end else begin
                    set_flag = 1;
                    if (m_os) m_en = 0;
                    else      m_value = m_load;
                end
            end
        end
        if (wr && m_addr == 2'd2) begin
            m_en  = wd[0];
            m_ie  = wd[1];
            m_os  = wd[2];
            m_psc = wd[15:8];
        end
        if (wr && m_addr == 2'd3 && wd[0]) m_flag = 0;
        if (set_flag) m_flag = 1;
        m_valid = HSEL && HREADY && HTRANS[1];
        if (m_valid) begin
            m_addr  = HADDR[3:2];
            m_write = HWRITE;
        end
    endtask

    initial begin
        forever begin
            @(posedge HCLK);
            model_step();
        end
    end

    // Per-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge HCLK);
            if (model_live) begin
                checks++;
                if (HRDATA !== m_rdata()) begin
                    errors++;
                    $display("FAIL model_hrdata t=%0t got 0x%08h expected 0x%08h", $time, HRDATA, m_rdata());
                end
                checks++;
                if (timer_IRQ !== (m_flag & m_ie)) begin
                    errors++;
                    $display("FAIL model_irq t=%0t got %b expected %b", $time, timer_IRQ, m_flag & m_ie);
                end
                checks++;
                if (HREADYOUT !== 1'b1) begin
                    errors++;
                    $display("FAIL model_hreadyout t=%0t got %b expected 1", $time, HREADYOUT);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus tasks start and end 2 ns after a rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a, 2'b00};
        @(posedge HCLK); #2;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #2;
        $display("WR reg=%0d data=0x%08h t=%0t", a, d, $time);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a, 2'b00};
        @(posedge HCLK); #2;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        $display("RD reg=%0d data=0x%08h t=%0t", a, d, $time);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_seq [6];

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HADDR = '0;
        HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = '0;
        repeat (2) @(posedge HCLK);
        #2 HRESETn = 1'b1;
        check("reset_hrdata", HRDATA, 32'h0);
        check("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("reset_irq", {31'h0, timer_IRQ}, 32'h0);

        // Periodic, PRESCALE 0: VALUE 3,2,1,0,4,3 after enable
        bus_write(2'd0, 32'd4);
        bus_write(2'd2, 32'h001);
        exp_seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd4, 32'd3};
        for (int i = 0; i < 6; i++) begin
            bus_read(2'd1, rd);
            check("periodic_value", rd, exp_seq[i]);
        end
        bus_read(2'd3, rd);
        check("periodic_flag", rd, 32'h1);
        check("periodic_irq_masked", {31'h0, timer_IRQ}, 32'h0);
        bus_write(2'd2, 32'h0);

        // Prescaled: first flag 12 cycles after enable
        bus_write(2'd3, 32'h1);
        bus_write(2'd0, 32'd2);
        bus_write(2'd2, 32'h303);
        repeat (11) @(posedge HCLK);
        #2 check("prescale_irq_cycle11", {31'h0, timer_IRQ}, 32'h0);
        @(posedge HCLK);
        #2 check("prescale_irq_cycle12", {31'h0, timer_IRQ}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("irq_after_clear", {31'h0, timer_IRQ}, 32'h0);
        bus_write(2'd2, 32'h0);

        // One-shot
        bus_write(2'd3, 32'h1);
        bus_write(2'd0, 32'd3);
        bus_write(2'd2, 32'h007);
        repeat (6) @(posedge HCLK);
        #2;
        bus_read(2'd2, rd);
        check("oneshot_ctrl", rd, 32'h6);
        bus_read(2'd1, rd);
        check("oneshot_value", rd, 32'h0);
        bus_read(2'd3, rd);
        check("oneshot_flag", rd, 32'h1);
        check("oneshot_irq", {31'h0, timer_IRQ}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("oneshot_irq_cleared", {31'h0, timer_IRQ}, 32'h0);

        // Clear-write colliding with flag set; LOAD write on a tick edge
        bus_write(2'd0, 32'd2);
        bus_write(2'd2, 32'h001);
        @(posedge HCLK); #2;
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rd);
        check("set_beats_clear", rd, 32'h1);
        bus_write(2'd0, 32'h10);
        bus_read(2'd1, rd);
        check("load_beats_tick", rd, 32'h0F);
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'h1);

        // VALUE is read-only; freeze and resume with PRESCALE 2
        bus_write(2'd1, 32'h55);
        bus_read(2'd1, rd);
        check("value_write_ignored", rd, 32'h0D);
        bus_write(2'd2, 32'h201);
        bus_write(2'd2, 32'h200);
        bus_read(2'd1, rd);
        check("freeze_value", rd, 32'h0D);
        repeat (4) @(posedge HCLK);
        #2;
        bus_read(2'd1, rd);
        check("freeze_value_held", rd, 32'h0D);
        bus_write(2'd2, 32'h201);
        bus_read(2'd1, rd);
        check("resume_value", rd, 32'h0C);
        bus_write(2'd2, 32'h0);

        // Reset mid-count with an outstanding LOAD write
        bus_write(2'd0, 32'd1);
        bus_write(2'd2, 32'h003);
        repeat (3) @(posedge HCLK);
        #2 check("pre_reset_irq", {31'h0, timer_IRQ}, 32'h1);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK); #2;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h77;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #2 HRESETn = 1'b1;
        check("post_reset_irq", {31'h0, timer_IRQ}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            check("post_reset_reg", rd, 32'h0);
        end
        repeat (4) @(posedge HCLK);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_timer.md
AHB_TIMER -- requirements
Module: ahb_timer

Interface
REQ-001 Parameter TIMER_WIDTH, default 32: counter and LOAD register width, fixed at 32 in this system.
REQ-002 Parameter PRESCALE_WIDTH, default 8: width of the CTRL.PRESCALE field and the prescale counter.
REQ-003 HCLK  input  1  bus clock, 50 MHz; the only clock.
REQ-004 HRESETn  input  1  bus reset; synchronous, active-low.
REQ-005 HSEL  input  1  slave select from address decoder.
REQ-006 HREADY  input  1  previous transfer completing.
REQ-007 HADDR  input  32  address; only [3:2] decoded.
REQ-008 HTRANS  input  2  transfer type; only bit 1 used.
REQ-009 HWRITE  input  1  write transfer.
REQ-010 HSIZE  input  3  transfer width; ignored, all accesses are 32-bit.
REQ-011 HWDATA  input  32  write data, valid in data phase.
REQ-012 HRDATA  output  32  read data.
REQ-013 HREADYOUT  output  1  constant 1 (zero wait states).
REQ-014 timer_IRQ  output  1  interrupt request to CPU IRQ[0], active high.

Function
REQ-015 Address phase SHALL be captured on an HCLK edge when HSEL & HREADY & HTRANS[1]; the registered HADDR[3:2] and HWRITE qualify the following data phase.
REQ-016 Register map (HADDR[3:2]): 0 LOAD RW; 1 VALUE RO (writes ignored); 2 CTRL RW; 3 STATUS (read flag, write 1 to bit0 clears).
REQ-017 CTRL bits: [0] EN, [1] IE, [2] ONESHOT, [15:8] PRESCALE; other bits read 0.
REQ-018 A write SHALL update its target register on the HCLK edge that ends the data phase, using HWDATA.
REQ-019 HRDATA SHALL be combinational from the registered address and the current register contents; unused bits read 0.
REQ-020 A LOAD write SHALL also copy HWDATA into VALUE and clear the prescale counter in the same edge.
REQ-021 While EN=1, the prescale counter SHALL increment each HCLK; when it equals PRESCALE it SHALL return to 0 and generate a one-cycle tick.
REQ-022 On a tick with VALUE≠0, VALUE SHALL decrement by 1.
REQ-023 On a tick with VALUE=0: set STATUS flag; if ONESHOT=0, VALUE←LOAD; if ONESHOT=1, clear EN and hold VALUE at 0.
REQ-024 Resulting periodic interval = (LOAD+1)×(PRESCALE+1) HCLK cycles.
REQ-025 EN=0 SHALL freeze VALUE and the prescale counter; setting EN again SHALL resume from the frozen values.
REQ-026 Simultaneous flag set and STATUS clear-write: set SHALL win.
REQ-027 Simultaneous LOAD write and tick: the write SHALL win; no decrement or flag that cycle.
REQ-028 Simultaneous CTRL write and ONESHOT auto-clear of EN: the bus-written EN value SHALL win.
REQ-029 VALUE SHALL wrap only via reload; it SHALL never decrement below 0.
REQ-030 timer_IRQ = STATUS flag & CTRL.IE, derived from registered state only.

Reset
REQ-031 While HRESETn=0 at an HCLK edge: LOAD, VALUE, CTRL, flag, prescale counter, and captured address/write-valid SHALL be 0.
REQ-032 After reset: HRDATA=0, HREADYOUT=1, timer_IRQ=0; a transfer in flight when reset asserts SHALL be discarded.

Structure
REQ-033 A shared package SHALL hold the register offsets (LOAD/VALUE/CTRL/STATUS) and the CTRL bit/field positions.
REQ-034 The prescaler SHALL be a sub-module, timer_prescaler (inputs: enable, clear, divisor; output: tick).
REQ-035 The top level SHALL be instantiated as an AHB-Lite slave alongside the existing slaves, with timer_IRQ driving IRQ[0].

Verification
REQ-036 LOAD=4, CTRL=0x001 (PRESCALE 0) -> VALUE 4,3,2,1,0,4… per cycle; flag set every 5 cycles; timer_IRQ stays 0.
REQ-037 LOAD=2, CTRL=0x0303 (PRESCALE 3, IE) -> first flag 12 cycles after EN; timer_IRQ=1; write STATUS=1 -> IRQ 0 the next cycle.
REQ-038 LOAD=3, CTRL=0x007 (ONESHOT) -> one flag, EN reads 0, VALUE holds 0 with no reload.
REQ-039 Clear-write on the same edge as a flag set -> flag remains 1; LOAD write on a tick edge -> VALUE = written value.
REQ-040 Write VALUE=0x55 -> ignored, reads old VALUE; EN toggled 1→0→1 -> VALUE frozen, then resumes.
REQ-041 Assert HRESETn=0 mid-count with an outstanding write -> all registers read 0, IRQ 0, and the write is not applied.
